// File: rtl/obi_mem_sbr_pkg.sv
// Shared constants and address helpers for the obi_mem_sbr OBI memory subordinate.
package obi_mem_sbr_pkg;

  localparam int unsigned MaxLatency = 4;

  // Word index of a byte address relative to the memory base address.
  function automatic logic [63:0] word_idx(input logic [63:0] addr,
                                           input logic [63:0] base,
                                           input int unsigned bytes_log2);
    return (addr - base) >> bytes_log2;
  endfunction

endpackage

// File: rtl/obi_mem_sbr_rsp_fifo.sv
// Fall-through response FIFO: data_out is valid in the same cycle the FIFO is non-empty.
module obi_mem_sbr_rsp_fifo #(
  parameter type         T     = logic [7:0],
  parameter int unsigned Depth = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     data_in,
  input  logic pop,
  output T     data_out,
  output logic empty,
  output logic full
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  T                store_r [Depth];
  logic [PtrW-1:0] wr_ptr_r;
  logic [PtrW-1:0] rd_ptr_r;
  logic [CntW-1:0] cnt_r;
  logic            do_push_s;
  logic            do_pop_s;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(Depth - 1)) begin
      return {PtrW{1'b0}};
    end else begin
      return p + PtrW'(1);
    end
  endfunction

  assign empty     = (cnt_r == {CntW{1'b0}});
  assign full      = (cnt_r == CntW'(Depth));
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign data_out  = empty ? '0 : store_r[rd_ptr_r];

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr_r <= {PtrW{1'b0}};
      rd_ptr_r <= {PtrW{1'b0}};
      cnt_r    <= {CntW{1'b0}};
      for (int unsigned i = 0; i < Depth; i++) store_r[i] <= '0;
    end else begin
      if (do_push_s) begin
        store_r[wr_ptr_r] <= data_in;
        wr_ptr_r          <= ptr_inc(wr_ptr_r);
      end
      if (do_pop_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
      if (do_push_s && !do_pop_s) begin
        cnt_r <= cnt_r + CntW'(1);
      end else if (!do_push_s && do_pop_s) begin
        cnt_r <= cnt_r - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/obi_mem_sbr.sv
// OBI subordinate backed by a word register memory with in-order, fixed-latency responses.
// Build option OBI_MEM_SBR_ERR_EN: out-of-range accesses return err=1 instead of aliasing.
module obi_mem_sbr
  import obi_mem_sbr_pkg::*;
#(
  parameter int unsigned          AddrWidth = 32,
  parameter int unsigned          DataWidth = 32,
  parameter int unsigned          IdWidth   = 5,
  parameter int unsigned          NumWords  = 256,
  parameter logic [AddrWidth-1:0] BaseAddr  = {AddrWidth{1'b0}},
  parameter int unsigned          Latency   = 1,
  parameter int unsigned          RspDepth  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic                   we_i,
  input  logic [DataWidth/8-1:0] be_i,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [IdWidth-1:0]     aid_i,
  output logic                   rvalid_o,
  input  logic                   rready_i,
  output logic [DataWidth-1:0]   rdata_o,
  output logic [IdWidth-1:0]     rid_o,
  output logic                   err_o
);

  localparam int unsigned BeW       = DataWidth / 8;
  localparam int unsigned BytesLog2 = $clog2(BeW);
  localparam int unsigned IdxW      = $clog2(NumWords);
  localparam int unsigned CntW      = $clog2(RspDepth + 1);

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic [IdWidth-1:0]   rid;
    logic                 err;
  } rsp_t;

  logic [DataWidth-1:0]  mem_r [NumWords];
  logic [63:0]           idx_full_s;
  logic [IdxW-1:0]       idx_s;
  logic                  in_range_s;
  logic                  a_hs_s;
  logic                  r_hs_s;
  logic                  gnt_r;
  logic [CntW-1:0]       cnt_r;
  logic [CntW-1:0]       cnt_next_s;
  rsp_t                  new_rsp_s;
  rsp_t                  pipe_r [1:MaxLatency-1];
  logic [MaxLatency-1:1] pipe_vld_r;
  rsp_t                  stage_s [MaxLatency];
  logic [MaxLatency-1:0] stage_vld_s;
  rsp_t                  rsp_out_s;
  logic                  fifo_empty_s;
  logic                  fifo_full_unused_s;

  assign idx_full_s = word_idx(64'(addr_i), 64'(BaseAddr), BytesLog2);
  assign idx_s      = idx_full_s[IdxW-1:0];

`ifdef OBI_MEM_SBR_ERR_EN
  assign in_range_s = (64'(addr_i) >= 64'(BaseAddr)) && (idx_full_s < 64'(NumWords));
`else
  logic unused_idx_s;
  assign unused_idx_s = ^idx_full_s[63:IdxW];
  assign in_range_s   = 1'b1;
`endif

  assign a_hs_s = req_i & gnt_r;
  assign r_hs_s = rvalid_o & rready_i;

  // Byte-enabled memory write at the accept edge; whole array clears on reset.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int unsigned i = 0; i < NumWords; i++) mem_r[i] <= {DataWidth{1'b0}};
    end else if (a_hs_s && we_i && in_range_s) begin
      for (int unsigned j = 0; j < BeW; j++) begin
        if (be_i[j]) mem_r[idx_s][j*8 +: 8] <= wdata_i[j*8 +: 8];
      end
    end
  end

  // Response captured from the pre-write memory contents at the accept edge.
  always_comb begin
    new_rsp_s.rid = aid_i;
    new_rsp_s.err = ~in_range_s;
    if (we_i || !in_range_s) begin
      new_rsp_s.rdata = {DataWidth{1'b0}};
    end else begin
      new_rsp_s.rdata = mem_r[idx_s];
    end
  end

  // Stage 0 is the live request; stage Latency-1 feeds the FIFO.
  always_comb begin
    stage_s[0]     = new_rsp_s;
    stage_vld_s[0] = a_hs_s;
    for (int unsigned k = 1; k < MaxLatency; k++) begin
      stage_s[k]     = pipe_r[k];
      stage_vld_s[k] = pipe_vld_r[k];
    end
  end

  // Outstanding count: accept and release in the same cycle cancel out.
  always_comb begin
    if (a_hs_s && !r_hs_s) begin
      cnt_next_s = cnt_r + CntW'(1);
    end else if (!a_hs_s && r_hs_s) begin
      cnt_next_s = cnt_r - CntW'(1);
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Latency shift pipeline, outstanding counter and registered grant.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int unsigned k = 1; k < MaxLatency; k++) pipe_r[k] <= '0;
      pipe_vld_r <= {(MaxLatency-1){1'b0}};
      cnt_r      <= {CntW{1'b0}};
      gnt_r      <= 1'b0;
    end else begin
      for (int unsigned k = 1; k < MaxLatency; k++) begin
        pipe_r[k]     <= stage_s[k-1];
        pipe_vld_r[k] <= stage_vld_s[k-1];
      end
      cnt_r <= cnt_next_s;
      gnt_r <= (cnt_next_s < CntW'(RspDepth));
    end
  end

  obi_mem_sbr_rsp_fifo #(
    .T     (rsp_t),
    .Depth (RspDepth)
  ) i_rsp_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (stage_vld_s[Latency-1]),
    .data_in  (stage_s[Latency-1]),
    .pop      (r_hs_s),
    .data_out (rsp_out_s),
    .empty    (fifo_empty_s),
    .full     (fifo_full_unused_s)
  );

  assign gnt_o    = gnt_r;
  assign rvalid_o = ~fifo_empty_s;
  assign rdata_o  = rsp_out_s.rdata;
  assign rid_o    = rsp_out_s.rid;
  assign err_o    = rsp_out_s.err;

endmodule

// File: tb/tb_obi_mem_sbr.sv
// Self-checking bench for obi_mem_sbr: directed table, backpressure, random traffic, Latency=3.
module tb_obi_mem_sbr;

  localparam int LAT = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        req = 1'b0, we = 1'b0, rready = 1'b1;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [3:0]  be = 4'h0;
  logic [4:0]  aid = 5'd0;
  logic        gnt, rvalid, err;
  logic [31:0] rdata;
  logic [4:0]  rid;

  logic        req3 = 1'b0, we3 = 1'b0, rready3 = 1'b1;
  logic [31:0] addr3 = 32'h0, wdata3 = 32'h0;
  logic [3:0]  be3 = 4'h0;
  logic [4:0]  aid3 = 5'd0;
  logic        gnt3, rvalid3, err3;
  logic [31:0] rdata3;
  logic [4:0]  rid3;

  obi_mem_sbr dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .aid_i(aid), .rvalid_o(rvalid), .rready_i(rready),
    .rdata_o(rdata), .rid_o(rid), .err_o(err)
  );

  obi_mem_sbr #(.Latency(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_i(req3), .gnt_o(gnt3), .addr_i(addr3), .we_i(we3),
    .be_i(be3), .wdata_i(wdata3), .aid_i(aid3), .rvalid_o(rvalid3), .rready_i(rready3),
    .rdata_o(rdata3), .rid_o(rid3), .err_o(err3)
  );

  // Reference model: transaction queue with the cycle each response becomes visible.
  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  rid;
    logic        err;
    int          ready;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [4:0]  aid;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  exp_t        exp_q[$];
  logic [31:0] mem_m [256];
  vec_t        vec [8];
  int          cyc = 0;
  bit          armed = 1'b0;
  int          grants = 0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_rvalid();
    return (exp_q.size() > 0) && (exp_q[0].ready <= cyc);
  endfunction

  task automatic check_outputs();
    chk("gnt", gnt, 64'(armed && (exp_q.size() < 4)));
    chk("rvalid", rvalid, 64'(exp_rvalid()));
    if (exp_rvalid()) begin
      chk("rdata", rdata, exp_q[0].rdata);
      chk("rid", rid, exp_q[0].rid);
      chk("err", err, exp_q[0].err);
    end
  endtask

  // Predict the effect of the coming rising edge from the inputs just driven.
  task automatic model_edge();
    bit          ahs, rhs, inr;
    int unsigned idx;
    exp_t        e;
    ahs = armed && (exp_q.size() < 4) && req;
    rhs = exp_rvalid() && rready;
    if (rhs) void'(exp_q.pop_front());
    cyc++;
    armed = 1'b1;
    if (ahs) begin
      idx = addr >> 2;
`ifdef OBI_MEM_SBR_ERR_EN
      inr = (idx < 256);
`else
      inr = 1'b1;
      idx = idx % 256;
`endif
      e.rid   = aid;
      e.err   = !inr;
      e.ready = cyc + LAT - 1;
      e.rdata = (!we && inr) ? mem_m[idx] : 32'h0;
      if (we && inr) begin
        for (int j = 0; j < 4; j++) if (be[j]) mem_m[idx][j*8 +: 8] = wdata[j*8 +: 8];
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic drive(input logic rq, input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, input logic [4:0] id, input logic rr);
    @(negedge clk);
    check_outputs();
    if (rq && gnt) grants++;
    req = rq; we = w; addr = a; be = b; wdata = d; aid = id; rready = rr;
    model_edge();
  endtask

  task automatic idle(input logic rr);
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 5'd0, rr);
  endtask

  // Called at a falling edge: holds reset two cycles, checks reset outputs, releases.
  task automatic do_reset();
    rst_n = 1'b1; req = 1'b0; req3 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rid", rid, 0);
    chk("rst_err", err, 0);
    chk("rst_gnt3", gnt3, 0);
    chk("rst_rvalid3", rvalid3, 0);
    exp_q.delete();
    for (int i = 0; i < 256; i++) mem_m[i] = 32'h0;
    armed = 1'b0;
    rst_n = 1'b0;
    model_edge();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

  initial begin
    bit got;
    logic [31:0] a;

    vec[0] = '{1'b1, 32'h100, 4'hF, 32'hDEADBEEF, 5'd3, 32'h0, 1'b0};
    vec[1] = '{1'b0, 32'h100, 4'hF, 32'h0, 5'd7, 32'hDEADBEEF, 1'b0};
    vec[2] = '{1'b1, 32'h020, 4'hF, 32'h11223344, 5'd1, 32'h0, 1'b0};
    vec[3] = '{1'b1, 32'h020, 4'b0101, 32'hAABBCCDD, 5'd2, 32'h0, 1'b0};
    vec[4] = '{1'b0, 32'h020, 4'hF, 32'h0, 5'd4, 32'h11BB33DD, 1'b0};
`ifdef OBI_MEM_SBR_ERR_EN
    vec[5] = '{1'b0, 32'h400, 4'hF, 32'h0, 5'd5, 32'h0, 1'b1};
    vec[6] = '{1'b1, 32'h400, 4'hF, 32'h5, 5'd6, 32'h0, 1'b1};
    vec[7] = '{1'b0, 32'h000, 4'hF, 32'h0, 5'd8, 32'h0, 1'b0};
`else
    vec[5] = '{1'b1, 32'h400, 4'hF, 32'h5, 5'd6, 32'h0, 1'b0};
    vec[6] = '{1'b0, 32'h000, 4'hF, 32'h0, 5'd8, 32'h5, 1'b0};
    vec[7] = '{1'b0, 32'h400, 4'hF, 32'h0, 5'd9, 32'h5, 1'b0};
`endif

    // Reset, then idle with no responses
    @(negedge clk);
    do_reset();
    repeat (4) idle(1'b1);

    // Directed table: one transaction at a time, response one cycle after accept
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vec[i].we, vec[i].addr, vec[i].be, vec[i].wdata, vec[i].aid, 1'b1);
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
        idle(1'b1);
        if (rvalid) begin
          got = 1'b1;
          chk("vec_latency", k, 0);
          chk("vec_rdata", rdata, vec[i].exp_rdata);
          chk("vec_rid", rid, vec[i].aid);
          chk("vec_err", err, vec[i].exp_err);
        end
      end
      chk("vec_rsp_seen", got, 1);
    end

    // Backpressure: continuous reads with rready low fill all four slots
    grants = 0;
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 32'h100, 4'hF, 32'h0, 5'(i), 1'b0);
    chk("bp_grants", grants, 4);
    idle(1'b0);
    chk("bp_gnt_low", gnt, 0);
    chk("bp_rvalid", rvalid, 1);
    chk("bp_rid", rid, 0);
    chk("bp_rdata", rdata, 32'hDEADBEEF);
    idle(1'b1);
    idle(1'b0);
    chk("bp_regnt", gnt, 1);
    repeat (8) idle(1'b1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      a = (32'($urandom_range(0, 7)) << 2) | (($urandom_range(0, 3) == 0) ? 32'h400 : 32'h0);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 4'($urandom), $urandom,
            5'($urandom), ($urandom_range(0, 9) < 7));
    end
    repeat (10) idle(1'b1);
    chk("drained", rvalid, 0);

    // Latency=3 instance: write then read, rvalid three cycles after accept
    @(negedge clk);
    chk("l3_gnt", gnt3, 1);
    req3 = 1'b1; we3 = 1'b1; addr3 = 32'h100; be3 = 4'hF; wdata3 = 32'hCAFE0001;
    aid3 = 5'd1; rready3 = 1'b1;
    @(negedge clk); req3 = 1'b0; chk("l3_w_t1", rvalid3, 0);
    @(negedge clk); chk("l3_w_t2", rvalid3, 0);
    @(negedge clk); chk("l3_w_t3", rvalid3, 1); chk("l3_w_rid", rid3, 1); chk("l3_w_rdata", rdata3, 0);
    @(negedge clk); chk("l3_w_pop", rvalid3, 0);
    req3 = 1'b1; we3 = 1'b0; aid3 = 5'd2;
    @(negedge clk); req3 = 1'b0; chk("l3_r_t1", rvalid3, 0);
    @(negedge clk); chk("l3_r_t2", rvalid3, 0);
    @(negedge clk); chk("l3_r_t3", rvalid3, 1); chk("l3_r_rid", rid3, 2);
    chk("l3_r_rdata", rdata3, 32'hCAFE0001); chk("l3_r_err", err3, 0);
    @(negedge clk); chk("l3_r_pop", rvalid3, 0);

    // Reset one cycle after an accept drops the pending response
    req3 = 1'b1; aid3 = 5'd3;
    @(negedge clk);
    req3 = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      idle(1'b1);
      chk("l3_rst_rvalid", rvalid3, 0);
      chk("l3_rst_gnt", gnt3, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
